uart_rx_os16: RTL and testbench
===============================

// Module: uart_rx_os16
// PURPOSE
//  16x-oversampling UART receiver with its own sample-tick divider, 2-FF rx synchronizer and 3-sample majority vote.
//  Validates start bit, checks optional parity and stop bit, detects line break and overrun.
//  Presents each frame on a valid/ready handshake.
//  Serves as the receive end for the team's transmitter when the serial link is noisy or asynchronous to rx clk.
// PARAMETERS
//  sys_clk     10000000  rx clock frequency in Hz
//  baud_rate   9600      line rate in bit/s
//  data_width  8         data bits per frame, 5..9
//  DIV (localparam) = sys_clk/(baud_rate*16), truncated; must be >= 1 (elaboration error otherwise)
// PORTS
//  clk                input  1           receive clock
//  rst                input  1           asynchronous active-high reset
//  rx                 input  1           serial line, idle high, asynchronous to clk
//  parity_en          input  1           1: frame carries a parity bit after the data
//  odd_r_even_parity  input  1           1: odd parity, 0: even parity (ones in data+parity)
//  ready              input  1           consumer accepts data_out when valid&&ready
//  data_out           output data_width  received data, LSB received first
//  valid              output 1           data_out and frame error flags are held
//  parity_error       output 1           parity mismatch for held frame (qualified by valid)
//  framing_error      output 1           stop bit sampled 0 for held frame (qualified by valid)
//  break_detect       output 1           held frame was all-zero data with stop bit 0
//  overrun_error      output 1           sticky; a completed frame was dropped while valid&&!ready
//  busy               output 1           state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, FSM=IDLE, synchronizer FFs=1, tick counter=0, sample counter=0.
//  - Tick: free-running counter 0..DIV-1; os_tick is a one-cycle pulse when the counter is DIV-1.
//  - rx_s is rx after 2 FFs. All sampling uses rx_s on os_tick only.
//  - Bit timing: each bit spans 16 ticks, index 0..15. Samples are taken at idx 7, 8 and 9. Bit value = majority of the 3 samples. Bit advances at idx 15.
//  - IDLE: on a tick with rx_s==0, go to START with idx=0.
//  - START: vote at idx 9.
//    - Vote 1 (glitch): go to IDLE with no output.
//    - Vote 0: continue to idx 15, then go to DATA.
//  - DATA: data_width bits shift in LSB first. After the last bit, go to PARITY if parity_en, else STOP.
//  - PARITY: compare the voted bit with the expected value. Even parity: XOR of data. Odd parity: ~XOR of data.
//  - STOP: vote at idx 9, then complete the frame at that same tick (no wait to idx 15) so the next start edge resyncs.
//    - Stop vote 1: go to IDLE.
//    - Stop vote 0 with all-zero data: go to BREAK.
//    - Stop vote 0 with nonzero data: go to IDLE.
//  - BREAK: stay until rx_s==1 on a tick, then go to IDLE. Line-low time in BREAK produces no further frames.
//  - Completion (1 clk after the idx-9 stop tick): valid<=1, and data_out, parity_error, framing_error, break_detect load together.
//  - Handshake:
//    - valid drops the cycle after valid&&ready.
//    - Completion while valid&&!ready: new frame discarded, held frame unchanged, overrun_error<=1.
//    - Completion in the same cycle as valid&&ready: new frame loads, valid stays 1, no overrun.
//  - overrun_error clears on the cycle after the next valid&&ready handshake. It is not cleared by a new frame.
//  - parity_en and odd_r_even_parity are sampled continuously and must be static while busy.
//  - Reset mid-frame: immediate return to reset state; a partial frame is never presented.
// TESTING  (sys_clk=16000, baud_rate=100 -> DIV=10, 160 clk/bit)
//  - 0xA5, no parity, stop 1, ready=1 -> one valid pulse, data_out=0xA5, all error flags 0.
//  - parity_en=1, odd=0, data 0x03 with parity bit 1 -> data_out=0x03, parity_error=1. Same frame with odd=1 -> parity_error=0.
//  - rx low for 30 clk (3 ticks) then high -> busy rises then falls, valid never asserts.
//  - 0x55 with stop bit 0 -> framing_error=1, break_detect=0.
//    - 20 bit-times of rx low -> exactly one valid with data 0x00, framing_error=1, break_detect=1.
//    - Then rx high + 0x3C -> 0x3C received cleanly.
//  - ready=0, frames 0x11 then 0x22 -> data_out stays 0x11, overrun_error=1. ready=1 for 1 clk -> valid and overrun_error both fall.
//  - 1-tick low glitch at idx 8 of data bit 2 in a 0xFF frame -> data_out=0xFF, no errors.
//  - rst pulse mid-DATA -> all outputs 0 within the reset; a following 0x7E frame is received correctly.

Source files
------------

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling UART receiver with a private sample-tick
// divider, a 2-FF synchronizer on rx, 3-sample majority voting per bit,
// optional parity, stop/break detection and a valid/ready output holding
// register with a sticky overrun flag.
module uart_rx_os16 #(
  parameter int sys_clk    = 10000000,
  parameter int baud_rate  = 9600,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  parity_en,
  input  logic                  odd_r_even_parity,
  input  logic                  ready,
  output logic [data_width-1:0] data_out,
  output logic                  valid,
  output logic                  parity_error,
  output logic                  framing_error,
  output logic                  break_detect,
  output logic                  overrun_error,
  output logic                  busy
);

  localparam int DIV = sys_clk / (baud_rate * 16);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  localparam logic [3:0]    LAST = 4'(data_width - 1);

  generate
    if (DIV < 1) begin : g_div_check
      $error("uart_rx_os16: sys_clk/(baud_rate*16) must be >= 1");
    end
    if (data_width < 5 || data_width > 9) begin : g_width_check
      $error("uart_rx_os16: data_width must be 5..9");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
  } state_t;

  state_t                state, state_n;
  logic [TW-1:0]         tcnt;
  logic                  os_tick;
  logic                  sync1, rx_s;
  logic [3:0]            idx;
  logic [3:0]            bcnt;
  logic [data_width-1:0] shreg;
  logic                  smp7, smp8;
  logic                  par_err;
  logic                  vote;
  logic                  at_vote, at_end;
  logic                  complete;
  logic                  accept;

  assign os_tick = (tcnt == TMAX);
  assign vote    = (smp7 & smp8) | (smp7 & rx_s) | (smp8 & rx_s);
  assign at_vote = os_tick && (idx == 4'd9);
  assign at_end  = os_tick && (idx == 4'd15);
  assign accept  = valid && ready;
  assign busy    = (state != S_IDLE);

  // Free-running oversample tick divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else if (os_tick) tcnt <= '0;
    else tcnt <= tcnt + TW'(1);
  end

  // Two-stage synchronizer for the asynchronous serial line (idle high).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else state <= state_n;
  end

  // Next-state logic; the stop bit completes the frame at its mid-bit vote
  // so a following start edge is seen without waiting out the bit.
  always_comb begin
    state_n  = state;
    complete = 1'b0;
    case (state)
      S_IDLE:   if (os_tick && !rx_s) state_n = S_START;
      S_START: begin
        if (at_vote && vote) state_n = S_IDLE;
        else if (at_end) state_n = S_DATA;
      end
      S_DATA:   if (at_end && bcnt == LAST) state_n = parity_en ? S_PARITY : S_STOP;
      S_PARITY: if (at_end) state_n = S_STOP;
      S_STOP: begin
        if (at_vote) begin
          complete = 1'b1;
          state_n  = (!vote && shreg == '0) ? S_BRK : S_IDLE;
        end
      end
      S_BRK:    if (os_tick && rx_s) state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // Bit-position counter, mid-bit samples, data shift and parity check.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      bcnt    <= '0;
      shreg   <= '0;
      smp7    <= 1'b1;
      smp8    <= 1'b1;
      par_err <= 1'b0;
    end else if (os_tick) begin
      idx <= (state == S_IDLE) ? 4'd0 : idx + 4'd1;
      if (idx == 4'd7) smp7 <= rx_s;
      if (idx == 4'd8) smp8 <= rx_s;
      case (state)
        S_IDLE: begin
          bcnt    <= '0;
          par_err <= 1'b0;
        end
        S_DATA: begin
          if (idx == 4'd9)  shreg <= {vote, shreg[data_width-1:1]};
          if (idx == 4'd15) bcnt  <= bcnt + 4'd1;
        end
        S_PARITY: if (idx == 4'd9) par_err <= (vote != (^shreg ^ odd_r_even_parity));
        default: ;
      endcase
    end
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out      <= '0;
      valid         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      break_detect  <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      if (complete && !(valid && !ready)) begin
        valid         <= 1'b1;
        data_out      <= shreg;
        parity_error  <= par_err;
        framing_error <= !vote;
        break_detect  <= !vote && (shreg == '0);
      end else if (accept) begin
        valid <= 1'b0;
      end
      if (accept) overrun_error <= 1'b0;
      else if (complete && valid) overrun_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// tb_uart_rx_os16: scoreboard bench for uart_rx_os16 at DIV=10 (160 clk/bit).
module tb_uart_rx_os16;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       parity_en;
  logic       odd_r_even_parity;
  logic       ready;
  logic [7:0] data_out;
  logic       valid, parity_error, framing_error, break_detect, overrun_error, busy;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       fe;
    logic       bd;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  uart_rx_os16 #(.sys_clk(16000), .baud_rate(100), .data_width(8)) dut (
    .clk(clk), .rst(rst), .rx(rx), .parity_en(parity_en),
    .odd_r_even_parity(odd_r_even_parity), .ready(ready),
    .data_out(data_out), .valid(valid), .parity_error(parity_error),
    .framing_error(framing_error), .break_detect(break_detect),
    .overrun_error(overrun_error), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input bit glitch);
    rx = v;
    if (glitch) begin
      hold(80);
      rx = 1'b0;
      hold(10);
      rx = v;
      hold(BIT - 90);
    end else begin
      hold(BIT);
    end
  endtask

  // Reference model: what the receiver must report for a frame, from the line-level rules.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic odd,
                            input logic pbit, input logic stop, input int glitch_bit,
                            input bit expect_out);
    exp_t e;
    parity_en = pen;
    odd_r_even_parity = odd;
    e.data = d;
    e.perr = pen && ((($countones(d) + int'(pbit)) % 2) != int'(odd));
    e.fe   = !stop;
    e.bd   = !stop && (d == 8'h00);
    if (expect_out) q.push_back(e);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i], i == glitch_bit);
    if (pen) drive_bit(pbit, 1'b0);
    drive_bit(stop, 1'b0);
    rx = 1'b1;
    hold(2 * BIT);
  endtask

  // Monitor: pops an expectation on every accepted output.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && ready === 1'b1) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got data %0h with empty scoreboard at %0t", data_out, $time);
        end else begin
          e = q.pop_front();
          check("data_out", 32'(data_out), 32'(e.data));
          check("parity_error", 32'(parity_error), 32'(e.perr));
          check("framing_error", 32'(framing_error), 32'(e.fe));
          check("break_detect", 32'(break_detect), 32'(e.bd));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, 32'(data_out), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_perr"}, 32'(parity_error), 0);
    check({tag, "_fe"}, 32'(framing_error), 0);
    check({tag, "_bd"}, 32'(break_detect), 0);
    check({tag, "_ovr"}, 32'(overrun_error), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    rx = 1'b1;
    parity_en = 1'b0;
    odd_r_even_parity = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    hold(2 * BIT);

    // Directed frames.
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b1);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, -1, 1'b1);

    // Short low pulse: busy must rise then fall, no frame.
    rx = 1'b0;
    hold(30);
    rx = 1'b1;
    n = 0;
    while (!busy && n < 50) begin hold(1); n++; end
    check("glitch_busy_rise", 32'(busy), 1);
    n = 0;
    while (busy && n < 400) begin hold(1); n++; end
    check("glitch_busy_fall", 32'(busy), 0);
    hold(BIT);

    // Framing error, then a line break, then a clean frame.
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b1);
    begin
      exp_t e;
      e.data = 8'h00; e.perr = 1'b0; e.fe = 1'b1; e.bd = 1'b1;
      q.push_back(e);
      rx = 1'b0;
      hold(20 * BIT);
      rx = 1'b1;
      hold(2 * BIT);
    end
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);

    // Overrun: second frame lost while the first is held.
    ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    @(negedge clk);
    check("ovr_valid_held", 32'(valid), 1);
    check("ovr_data_held", 32'(data_out), 32'h11);
    check("ovr_flag", 32'(overrun_error), 1);
    @(posedge clk); #1;
    ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    @(negedge clk);
    check("ovr_valid_drop", 32'(valid), 0);
    check("ovr_flag_clear", 32'(overrun_error), 0);
    ready = 1'b1;

    // Mid-bit glitch on data bit 2 is outvoted.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1);

    // Randomized frames against the reference model.
    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      logic pen, odd, pbit, stop;
      d    = 8'($urandom);
      pen  = 1'($urandom);
      odd  = 1'($urandom);
      pbit = 1'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, pen, odd, pbit, stop, -1, 1'b1);
    end

    // Reset in the middle of a frame while a frame is held.
    ready = 1'b0;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);
    @(negedge clk);
    check("pre_reset_valid", 32'(valid), 1);
    @(posedge clk); #1;
    drive_bit(1'b0, 1'b0);
    drive_bit(1'b1, 1'b0);
    drive_bit(1'b0, 1'b0);
    check("pre_reset_busy", 32'(busy), 1);
    rst = 1'b1;
    rx = 1'b1;
    #2;
    check_all_zero("mid_reset");
    q.delete();
    hold(3);
    rst = 1'b0;
    ready = 1'b1;
    hold(2 * BIT);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b1);

    n = 0;
    while (q.size() != 0 && n < 4000) begin hold(1); n++; end
    check("scoreboard_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
